boot_progress_monitor: RTL and testbench
========================================

// Module: boot_progress_monitor
// PURPOSE
//  Synthesizable boot-sequence checker for the QSPI-to-IRAM bootloader path.
//  Counts QSPI read triggers and IRAM word writes on NUM_CH independent write ports,
//  checks that each port's write address never decreases, and watches the fetch PC.
//  Reports PASS on the jump to BOOT_TARGET, or FAIL on trap, early jump or timeout.
//  Sits beside the SoC interconnect; its status outputs go to GPIO or debug.
// PARAMETERS
//  ADDR_W       32             address width of write ports and PC
//  NUM_CH       2              number of monitored IRAM write ports
//  CNT_W        16             width of QSPI and word counters (saturating)
//  BOOT_TARGET  32'h0010_0000  PC value that marks a completed boot
//  TRAP_ADDR    32'hFFFF_FE44  PC value that marks a trap
//  MIN_WORDS    4              minimum IRAM words required before the jump
//  TIMEOUT_CYC  25000          cycles allowed in BOOT state; 0 disables the timeout
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous reset, active-high
//  arm_i        in   1               level; starts monitoring when high in IDLE
//  qspi_start_i in   1               one-cycle pulse per flash read transaction
//  wr_fire_i    in   NUM_CH          per-port write handshake (awvalid&wvalid&awready)
//  wr_addr_i    in   NUM_CH*ADDR_W   per-port write address; port k = [k*ADDR_W +: ADDR_W]
//  pc_valid_i   in   1               instruction fetch request valid
//  pc_i         in   ADDR_W          instruction fetch address
//  state_o      out  2               00 IDLE, 01 BOOT, 10 PASS, 11 FAIL
//  qspi_cnt_o   out  CNT_W           QSPI starts seen in BOOT
//  word_cnt_o   out  CNT_W           IRAM words written in BOOT (all ports)
//  err_code_o   out  3               0 none, 1 trap, 2 non-monotonic, 3 early jump, 4 timeout
//  err_ch_o     out  $clog2(NUM_CH)+1  port index of the non-monotonic error, else 0
//  done_o       out  1               1 in PASS or FAIL (sticky)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state IDLE; counters, err_code_o, err_ch_o and done_o are 0; per-port "seen" flags are cleared.
//  IDLE: ignores all inputs; arm_i=1 -> BOOT on the next edge; counters and timer clear.
//  BOOT (per cycle, all checks evaluated on the same sampled inputs):
//   - qspi_cnt += qspi_start_i; word_cnt += popcount(wr_fire_i); both saturate at 2^CNT_W-1.
//   - Port k fire: if seen[k] and wr_addr < last[k], flag a non-monotonic error; then last[k] <= wr_addr, seen[k] <= 1.
//     An equal address is legal (rewrite). Ports are checked independently, never against each other.
//   - pc_valid_i & pc_i==TRAP_ADDR -> trap error.
//   - pc_valid_i & pc_i==BOOT_TARGET: if word_cnt (including this cycle's writes) is >= MIN_WORDS -> PASS; else early-jump error.
//   - Timer increments each BOOT cycle. If TIMEOUT_CYC!=0 and timer reaches TIMEOUT_CYC-1 with no other event -> timeout error.
//   - Priority when several events fire in one cycle: trap > non-monotonic > early jump > PASS > timeout.
//     On simultaneous non-monotonic errors on several ports, err_ch_o reports the lowest index.
//   - Any error -> FAIL with err_code_o latched.
//  PASS/FAIL: terminal and sticky; counters freeze; done_o=1; only rst leaves these states (arm_i is ignored).
//  Outputs are registered: state and counter updates are visible 1 cycle after the sampled edge.
//  rst asserted mid-BOOT: same as power-on reset, so all tracking restarts from IDLE.
// TESTING
//  1 arm, 8 QSPI pulses, port0 writes 0x0010_0000..0x0010_00FC step 4 (64 words), then PC=0x0010_0000
//    -> PASS, qspi_cnt=8, word_cnt=64, err=0.
//  2 Port0 writes 0x100008 then 0x100004 -> FAIL, err=2, err_ch=0 one cycle later;
//    later writes do not change counters.
//  3 Only 3 words written, then PC=BOOT_TARGET -> FAIL, err=3. Repeat with the 4th write in the same cycle as the jump -> PASS.
//  4 Both ports fire in the same cycle (port0 rising, port1 0x200 after 0x300), with PC=TRAP_ADDR in that cycle
//    -> err=1 (trap wins), word_cnt +2.
//  5 TIMEOUT_CYC=100, arm, no PC hit -> FAIL, err=4 exactly 100 cycles after entering BOOT. With TIMEOUT_CYC=0 -> stays in BOOT.
//  6 CNT_W=4: 20 writes -> word_cnt saturates at 15; rst pulse mid-BOOT -> IDLE, all zero; re-arm works.

Source files
------------

// File: rtl/boot_progress_monitor.sv
// Boot-sequence checker for the QSPI-to-IRAM bootloader path.
// Counts QSPI read starts and IRAM word writes across NUM_CH write ports.
// Checks that each port's write address never decreases.
// Watches the fetch PC and reports PASS on the jump to BOOT_TARGET.
// Reports FAIL on a trap, an early jump, a decreasing address or a timeout.
module boot_progress_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_CH      = 2,
  parameter int                CNT_W       = 16,
  parameter logic [ADDR_W-1:0] BOOT_TARGET = 32'h0010_0000,
  parameter logic [ADDR_W-1:0] TRAP_ADDR   = 32'hFFFF_FE44,
  parameter int                MIN_WORDS   = 4,
  parameter int                TIMEOUT_CYC = 25000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm_i,
  input  logic                         qspi_start_i,
  input  logic [NUM_CH-1:0]            wr_fire_i,
  input  logic [NUM_CH*ADDR_W-1:0]     wr_addr_i,
  input  logic                         pc_valid_i,
  input  logic [ADDR_W-1:0]            pc_i,
  output logic [1:0]                   state_o,
  output logic [CNT_W-1:0]             qspi_cnt_o,
  output logic [CNT_W-1:0]             word_cnt_o,
  output logic [2:0]                   err_code_o,
  output logic [$clog2(NUM_CH):0]      err_ch_o,
  output logic                         done_o
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TRAP    = 3'd1;
  localparam logic [2:0] ERR_NONMONO = 3'd2;
  localparam logic [2:0] ERR_EARLY   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BOOT = 2'b01,
    ST_PASS = 2'b10,
    ST_FAIL = 2'b11
  } state_t;

  // Number of ports firing in this cycle.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_err;
  logic [2:0]          w_err_nxt;
  logic [CH_W-1:0]     r_err_ch;
  logic [CH_W-1:0]     w_err_ch_nxt;
  logic                r_done;
  logic [CNT_W-1:0]    r_qspi_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [31:0]         r_timer;
  logic [ADDR_W-1:0]   r_last [NUM_CH];
  logic [NUM_CH-1:0]   r_seen;

  logic [CNT_W-1:0]    w_word_inc;
  logic                w_trap;
  logic                w_jump;
  logic                w_enough;
  logic                w_timeout;
  logic                w_nonmono;
  logic [CH_W-1:0]     w_nm_ch;

  // Event detection on the sampled inputs, shared by FSM and datapath.
  always_comb begin
    w_word_inc = sat_add(r_word_cnt, popcount(wr_fire_i));
    w_trap     = pc_valid_i && (pc_i == TRAP_ADDR);
    w_jump     = pc_valid_i && (pc_i == BOOT_TARGET);
    // The word count used for the jump check includes this cycle's writes.
    w_enough   = (int'(w_word_inc) >= MIN_WORDS);
    w_timeout  = (TIMEOUT_CYC != 0) && (r_timer == 32'(TIMEOUT_CYC - 1));
    w_nonmono  = 1'b0;
    w_nm_ch    = '0;
    // Scan from the top so the lowest offending port index is kept.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (wr_fire_i[k] && r_seen[k] &&
          (wr_addr_i[k*ADDR_W +: ADDR_W] < r_last[k])) begin
        w_nonmono = 1'b1;
        w_nm_ch   = CH_W'(k);
      end else begin
        w_nonmono = w_nonmono;
      end
    end
  end

  // FSM state, latched error code/port and sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_err    <= ERR_NONE;
      r_err_ch <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_err    <= w_err_nxt;
      r_err_ch <= w_err_ch_nxt;
      r_done   <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
    end
  end

  // Next-state decision with fixed event priority:
  // trap, non-monotonic, early jump, pass, timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_err_nxt    = r_err;
    w_err_ch_nxt = r_err_ch;
    case (r_state)
      ST_IDLE: begin
        if (arm_i) begin
          w_state_nxt = ST_BOOT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BOOT: begin
        if (w_trap) begin
          w_state_nxt = ST_FAIL;
          w_err_nxt   = ERR_TRAP;
        end else if (w_nonmono) begin
          w_state_nxt  = ST_FAIL;
          w_err_nxt    = ERR_NONMONO;
          w_err_ch_nxt = w_nm_ch;
        end else if (w_jump && !w_enough) begin
          w_state_nxt = ST_FAIL;
          w_err_nxt   = ERR_EARLY;
        end else if (w_jump) begin
          w_state_nxt = ST_PASS;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAIL;
          w_err_nxt   = ERR_TIMEOUT;
        end else begin
          w_state_nxt = ST_BOOT;
        end
      end
      ST_PASS: w_state_nxt = ST_PASS;
      ST_FAIL: w_state_nxt = ST_FAIL;
      default: begin
        w_state_nxt  = ST_IDLE;
        w_err_nxt    = ERR_NONE;
        w_err_ch_nxt = '0;
      end
    endcase
  end

  // Counters, timer and per-port address tracking; frozen outside BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qspi_cnt <= '0;
      r_word_cnt <= '0;
      r_timer    <= '0;
      r_seen     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_last[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_qspi_cnt <= '0;
          r_word_cnt <= '0;
          r_timer    <= '0;
          r_seen     <= '0;
        end
        ST_BOOT: begin
          r_qspi_cnt <= sat_add(r_qspi_cnt, PC_W'(qspi_start_i));
          r_word_cnt <= w_word_inc;
          if (TIMEOUT_CYC != 0) begin
            r_timer <= r_timer + 32'd1;
          end else begin
            r_timer <= r_timer;
          end
          for (int k = 0; k < NUM_CH; k++) begin
            if (wr_fire_i[k]) begin
              r_last[k] <= wr_addr_i[k*ADDR_W +: ADDR_W];
              r_seen[k] <= 1'b1;
            end else begin
              r_last[k] <= r_last[k];
            end
          end
        end
        default: begin
          r_qspi_cnt <= r_qspi_cnt;
          r_word_cnt <= r_word_cnt;
        end
      endcase
    end
  end

  assign state_o    = r_state;
  assign qspi_cnt_o = r_qspi_cnt;
  assign word_cnt_o = r_word_cnt;
  assign err_code_o = r_err;
  assign err_ch_o   = r_err_ch;
  assign done_o     = r_done;

endmodule

// File: tb/tb_boot_progress_monitor.sv
// Directed bench for boot_progress_monitor: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (pass, timeout, saturation).
module tb_boot_progress_monitor;

  localparam logic [31:0] BT = 32'h0010_0000;
  localparam logic [31:0] TR = 32'hFFFF_FE44;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm_i = 1'b0;
  logic        qspi_start_i = 1'b0;
  logic [1:0]  wr_fire_i = 2'b00;
  logic [63:0] wr_addr_i = 64'h0;
  logic        pc_valid_i = 1'b0;
  logic [31:0] pc_i = 32'h0;

  // main instance: default parameters
  logic [1:0]  m_state;
  logic [15:0] m_qc, m_wc;
  logic [2:0]  m_err;
  logic [1:0]  m_ch;
  logic        m_done;
  // short-timeout instance
  logic [1:0]  t_state;
  logic [15:0] t_qc, t_wc;
  logic [2:0]  t_err;
  logic [1:0]  t_ch;
  logic        t_done;
  // no-timeout, 4-bit counter instance
  logic [1:0]  n_state;
  logic [3:0]  n_qc, n_wc;
  logic [2:0]  n_err;
  logic [1:0]  n_ch;
  logic        n_done;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  boot_progress_monitor u_dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .qspi_start_i(qspi_start_i),
    .wr_fire_i(wr_fire_i), .wr_addr_i(wr_addr_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
    .state_o(m_state), .qspi_cnt_o(m_qc), .word_cnt_o(m_wc),
    .err_code_o(m_err), .err_ch_o(m_ch), .done_o(m_done));

  boot_progress_monitor #(.TIMEOUT_CYC(100)) u_dut_to (
    .clk(clk), .rst(rst), .arm_i(arm_i), .qspi_start_i(qspi_start_i),
    .wr_fire_i(wr_fire_i), .wr_addr_i(wr_addr_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
    .state_o(t_state), .qspi_cnt_o(t_qc), .word_cnt_o(t_wc),
    .err_code_o(t_err), .err_ch_o(t_ch), .done_o(t_done));

  boot_progress_monitor #(.CNT_W(4), .TIMEOUT_CYC(0)) u_dut_nt (
    .clk(clk), .rst(rst), .arm_i(arm_i), .qspi_start_i(qspi_start_i),
    .wr_fire_i(wr_fire_i), .wr_addr_i(wr_addr_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
    .state_o(n_state), .qspi_cnt_o(n_qc), .word_cnt_o(n_wc),
    .err_code_o(n_err), .err_ch_o(n_ch), .done_o(n_done));

  typedef struct {
    logic        rst;
    logic        arm;
    logic        qspi;
    logic [1:0]  fire;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        pv;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [15:0] qc;
    logic [15:0] wc;
    logic [2:0]  err;
    logic [1:0]  ch;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic a, input logic q,
                              input logic [1:0] f, input logic [31:0] a0,
                              input logic [31:0] a1, input logic pv,
                              input logic [31:0] pc, input logic [1:0] st,
                              input int qc, input int wc, input logic [2:0] er,
                              input logic [1:0] ch, input logic dn);
    vec_t v;
    v.rst = r;  v.arm = a;  v.qspi = q; v.fire = f;
    v.a0 = a0;  v.a1 = a1;  v.pv = pv;  v.pc = pc;
    v.st = st;  v.qc = 16'(qc); v.wc = 16'(wc);
    v.err = er; v.ch = ch;  v.done = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic q, input logic [1:0] f,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic pv, input logic [31:0] pc);
    rst = r; arm_i = a; qspi_start_i = q; wr_fire_i = f;
    wr_addr_i = {a1, a0}; pc_valid_i = pv; pc_i = pc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_in();
  endtask

  task automatic do_arm();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_in();
  endtask

  initial begin
    // rst arm q fire a0 a1 pv pc | st qc wc err ch done
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,1,2'b11,32'h8,32'h8,1,TR,           2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,1,2'b01,32'h100008,32'h0,0,32'h0,   2'b01,1,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h100008,32'h0,0,TR,      2'b01,1,2,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b11,32'h100004,32'h50,0,32'h0,  2'b11,1,4,3'd2,2'd0,1));
    tbl.push_back(mk(0,1,1,2'b11,32'h200000,32'h60,1,BT,     2'b11,1,4,3'd2,2'd0,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b10,32'h0,32'h300,0,32'h0,      2'b01,0,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b11,32'h100,32'h200,1,TR,       2'b11,0,3,3'd1,2'd0,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h10,32'h0,0,32'h0,       2'b01,0,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b10,32'h0,32'h8,0,32'h0,        2'b01,0,2,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b10,32'h0,32'h4,0,32'h0,        2'b11,0,3,3'd2,2'd1,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b11,32'h20,32'h20,0,32'h0,      2'b01,0,2,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b11,32'h1c,32'h1c,0,32'h0,      2'b11,0,4,3'd2,2'd0,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h0,32'h0,0,32'h0,        2'b01,0,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h4,32'h0,0,32'h0,        2'b01,0,2,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h8,32'h0,0,32'h0,        2'b01,0,3,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b00,32'h0,32'h0,1,BT,           2'b11,0,3,3'd3,2'd0,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h0,32'h0,0,32'h0,        2'b01,0,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h4,32'h0,0,32'h0,        2'b01,0,2,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h8,32'h0,0,32'h0,        2'b01,0,3,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'hC,32'h0,1,BT,           2'b10,0,4,3'd0,2'd0,1));
    tbl.push_back(mk(0,1,1,2'b01,32'h10,32'h0,1,TR,          2'b10,0,4,3'd0,2'd0,1));
    tbl.push_back(mk(1,0,0,2'b00,32'h0,32'h0,0,32'h0,        2'b00,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,1,0,2'b00,32'h0,32'h0,0,32'h0,        2'b01,0,0,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h8,32'h0,0,32'h0,        2'b01,0,1,3'd0,2'd0,0));
    tbl.push_back(mk(0,0,0,2'b01,32'h4,32'h0,1,BT,           2'b11,0,2,3'd2,2'd0,1));

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].arm, tbl[i].qspi, tbl[i].fire,
            tbl[i].a0, tbl[i].a1, tbl[i].pv, tbl[i].pc);
      tick();
      chk($sformatf("v%0d_state", i), 32'(m_state), 32'(tbl[i].st));
      chk($sformatf("v%0d_qspi",  i), 32'(m_qc),    32'(tbl[i].qc));
      chk($sformatf("v%0d_words", i), 32'(m_wc),    32'(tbl[i].wc));
      chk($sformatf("v%0d_err",   i), 32'(m_err),   32'(tbl[i].err));
      chk($sformatf("v%0d_errch", i), 32'(m_ch),    32'(tbl[i].ch));
      chk($sformatf("v%0d_done",  i), 32'(m_done),  32'(tbl[i].done));
    end

    // Full boot: 8 QSPI pulses, 64 ascending words, then the jump.
    do_reset();
    do_arm();
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b0, (i < 8), 2'b01, 32'h0010_0000 + 32'(4 * i), 32'h0, 1'b0, 32'h0);
      tick();
    end
    chk("boot_state_pre", 32'(m_state), 32'd1);
    chk("boot_qspi_pre",  32'(m_qc),    32'd8);
    chk("boot_words_pre", 32'(m_wc),    32'd64);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, BT);
    tick();
    idle_in();
    chk("boot_state", 32'(m_state), 32'd2);
    chk("boot_qspi",  32'(m_qc),    32'd8);
    chk("boot_words", 32'(m_wc),    32'd64);
    chk("boot_err",   32'(m_err),   32'd0);
    chk("boot_done",  32'(m_done),  32'd1);

    // Timeout: FAIL exactly 100 cycles after entering BOOT; disabled instance stays.
    do_reset();
    do_arm();
    chk("to_entered", 32'(t_state), 32'd1);
    for (int i = 0; i < 99; i++) tick();
    chk("to_state_99",  32'(t_state), 32'd1);
    chk("to_err_99",    32'(t_err),   32'd0);
    tick();
    chk("to_state_100", 32'(t_state), 32'd3);
    chk("to_err_100",   32'(t_err),   32'd4);
    chk("to_done_100",  32'(t_done),  32'd1);
    for (int i = 0; i < 150; i++) tick();
    chk("nt_state", 32'(n_state), 32'd1);
    chk("nt_err",   32'(n_err),   32'd0);
    chk("nt_done",  32'(n_done),  32'd0);
    chk("main_no_early_timeout", 32'(m_state), 32'd1);

    // Saturation with 4-bit counters, then reset mid-BOOT and re-arm.
    do_reset();
    do_arm();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'b01, 32'h1000 + 32'(4 * i), 32'h0, 1'b0, 32'h0);
      tick();
    end
    idle_in();
    chk("sat_words_4b",  32'(n_wc),    32'd15);
    chk("sat_words_16b", 32'(m_wc),    32'd20);
    chk("sat_state",     32'(n_state), 32'd1);
    do_reset();
    chk("rst_state", 32'(n_state), 32'd0);
    chk("rst_words", 32'(n_wc),    32'd0);
    chk("rst_main_words", 32'(m_wc), 32'd0);
    chk("rst_done",  32'(n_done),  32'd0);
    do_arm();
    chk("rearm_state", 32'(n_state), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_in();
    chk("rearm_state2", 32'(n_state), 32'd1);
    chk("rearm_words",  32'(n_wc),    32'd1);
    chk("rearm_qspi",   32'(n_qc),    32'd1);
    chk("rearm_main_err", 32'(m_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
